// File: rtl/calc_cmd_sequencer.sv
// Command sequencer in front of the FSM calculator: buffers whole commands, serialises them
// onto iniciar/dados with the calculator's fixed timing, and returns results or timeouts.
module calc_cmd_sequencer #(
    parameter int WORD_WIDTH = 8,
    parameter int RES_WIDTH  = 8,
    parameter int CMD_DEPTH  = 2,
    parameter int TIMEOUT    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [3:0]            cmd_a,
    input  logic [3:0]            cmd_b,
    input  logic [2:0]            cmd_op,
    output logic                  iniciar,
    output logic [WORD_WIDTH-1:0] dados,
    input  logic                  pronto,
    input  logic [RES_WIDTH-1:0]  cal_result,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [RES_WIDTH-1:0]  rsp_result,
    output logic                  rsp_timeout,
    output logic                  busy
);
    localparam int AW = $clog2(CMD_DEPTH);
    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam int EW = 11;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_SEND_A    = 3'd2,
        S_SEND_B    = 3'd3,
        S_SEND_OP   = 3'd4,
        S_WAIT_DONE = 3'd5,
        S_RESP      = 3'd6
    } state_t;

    function automatic logic [WORD_WIDTH-1:0] zext4(input logic [3:0] v);
        logic [WORD_WIDTH-1:0] r;
        r      = '0;
        r[3:0] = v;
        return r;
    endfunction

    state_t                r_state;
    logic [EW-1:0]         r_mem [CMD_DEPTH];
    logic [AW:0]           r_wr_ptr;
    logic [AW:0]           r_rd_ptr;
    logic                  r_full;
    logic [3:0]            r_work_a;
    logic [3:0]            r_work_b;
    logic [2:0]            r_work_op;
    logic [CW-1:0]         r_cnt;
    logic                  r_iniciar;
    logic [WORD_WIDTH-1:0] r_dados;
    logic                  r_rsp_valid;
    logic [RES_WIDTH-1:0]  r_rsp_result;
    logic                  r_rsp_timeout;
    logic                  r_busy;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_empty;
    logic [AW:0]           w_wr_nxt;
    logic [AW:0]           w_rd_nxt;
    logic                  w_full_nxt;
    logic [EW-1:0]         w_head;

    // cmd_ready comes only from the registered full flag, so a full FIFO never takes a push
    assign w_push     = cmd_valid & ~r_full;
    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_pop      = (r_state == S_IDLE) & ~w_empty;
    assign w_wr_nxt   = r_wr_ptr + {{AW{1'b0}}, w_push};
    assign w_rd_nxt   = r_rd_ptr + {{AW{1'b0}}, w_pop};
    assign w_full_nxt = (w_wr_nxt[AW] != w_rd_nxt[AW]) &&
                        (w_wr_nxt[AW-1:0] == w_rd_nxt[AW-1:0]);
    assign w_head     = r_mem[r_rd_ptr[AW-1:0]];

    assign cmd_ready   = ~r_full;
    assign iniciar     = r_iniciar;
    assign dados       = r_dados;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_result  = r_rsp_result;
    assign rsp_timeout = r_rsp_timeout;
    assign busy        = r_busy;

    // FIFO storage, written on every accepted push
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {cmd_a, cmd_b, cmd_op};
        end
    end

    // FIFO pointers and registered full flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_full   <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_nxt;
            r_rd_ptr <= w_rd_nxt;
            r_full   <= w_full_nxt;
        end
    end

    // Sequencer FSM; every output is loaded together with the state it belongs to
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_work_a      <= 4'd0;
            r_work_b      <= 4'd0;
            r_work_op     <= 3'd0;
            r_cnt         <= '0;
            r_iniciar     <= 1'b0;
            r_dados       <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_result  <= '0;
            r_rsp_timeout <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        {r_work_a, r_work_b, r_work_op} <= w_head;
                        r_iniciar <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= S_START;
                    end else begin
                        r_busy    <= 1'b0;
                    end
                end
                S_START: begin
                    r_iniciar <= 1'b0;
                    r_dados   <= zext4(r_work_a);
                    r_state   <= S_SEND_A;
                end
                S_SEND_A: begin
                    r_dados <= zext4(r_work_b);
                    r_state <= S_SEND_B;
                end
                S_SEND_B: begin
                    r_dados <= zext4({1'b0, r_work_op});
                    r_state <= S_SEND_OP;
                end
                S_SEND_OP: begin
                    r_dados <= '0;
                    r_cnt   <= '0;
                    r_state <= S_WAIT_DONE;
                end
                // pronto only matters here, so stale pulses in earlier states are ignored
                S_WAIT_DONE: begin
                    if (pronto) begin
                        r_rsp_result  <= cal_result;
                        r_rsp_timeout <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= S_RESP;
                    end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        r_rsp_result  <= '0;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_rsp_valid <= 1'b1;
                    end
                end
                default: begin
                    r_iniciar   <= 1'b0;
                    r_dados     <= '0;
                    r_rsp_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end
endmodule
